cordic_sched: RTL and testbench

- Two-requester round-robin scheduler in front of the shared pipelined cordic_top core.
- Accepts vectoring (mode 1) and rotation (mode 2) jobs from two independent valid/ready ports and issues at most one job per cycle to the core.
- Tracks requester ownership through the fixed core latency and returns each core result to the requester that issued it.
- Sits between the two datapath clients and a single cordic_top instance.

---
 rtl/cordic_sched.sv | 173 +++++++++++++++++
 tb/tb_cordic_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sched.sv
// cordic_sched: two-port round-robin job scheduler for a shared
// pipelined CORDIC core, with per-job requester tagging through the core.
module cordic_sched #(
    parameter int IN_WIDTH  = 17,
    parameter int OUT_WIDTH = 17,
    parameter int CORE_LAT  = 18,
    parameter int CNT_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hold,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [1:0]           req0_mode,
    input  logic [IN_WIDTH-1:0]  req0_x,
    input  logic [IN_WIDTH-1:0]  req0_y,
    input  logic [IN_WIDTH-1:0]  req0_z,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [1:0]           req1_mode,
    input  logic [IN_WIDTH-1:0]  req1_x,
    input  logic [IN_WIDTH-1:0]  req1_y,
    input  logic [IN_WIDTH-1:0]  req1_z,
    output logic                 rsp0_valid,
    output logic                 rsp1_valid,
    output logic [OUT_WIDTH-1:0] rsp_r,
    output logic [OUT_WIDTH-1:0] rsp_a,
    output logic                 err0,
    output logic                 err1,
    output logic                 core_en,
    output logic [1:0]           core_mode,
    output logic [IN_WIDTH-1:0]  core_x,
    output logic [IN_WIDTH-1:0]  core_y,
    output logic [IN_WIDTH-1:0]  core_z,
    input  logic [OUT_WIDTH-1:0] core_r,
    input  logic [OUT_WIDTH-1:0] core_a,
    output logic [CNT_W-1:0]     in_flight,
    output logic                 idle
);

    logic                r_rr;
    logic                r_core_en;
    logic [1:0]          r_core_mode;
    logic [IN_WIDTH-1:0] r_core_x;
    logic [IN_WIDTH-1:0] r_core_y;
    logic [IN_WIDTH-1:0] r_core_z;
    logic [CORE_LAT:0]   r_tag_v;
    logic [CORE_LAT:0]   r_tag_id;
    logic                r_rsp0;
    logic                r_rsp1;
    logic                r_err0;
    logic                r_err1;
    logic [CNT_W-1:0]    r_inflight;

    logic                w_g0;
    logic                w_g1;
    logic                w_grant;
    logic [1:0]          w_mode;
    logic [IN_WIDTH-1:0] w_x;
    logic [IN_WIDTH-1:0] w_y;
    logic [IN_WIDTH-1:0] w_z;
    logic                w_legal;
    logic                w_issue;
    logic                w_retire;

    // Grant: a lone requester always wins; on contention the rr pointer decides.
    always_comb begin
        w_g0 = !hold && req0_valid && (!req1_valid || !r_rr);
        w_g1 = !hold && req1_valid && (!req0_valid ||  r_rr);
    end

    assign w_grant  = w_g0 | w_g1;
    assign w_mode   = w_g1 ? req1_mode : req0_mode;
    assign w_x      = w_g1 ? req1_x : req0_x;
    assign w_y      = w_g1 ? req1_y : req0_y;
    assign w_z      = w_g1 ? req1_z : req0_z;
    assign w_legal  = (w_mode == 2'd1) || (w_mode == 2'd2);
    assign w_issue  = w_grant && w_legal;
    assign w_retire = r_tag_v[CORE_LAT];

    // Round-robin pointer moves to the loser after every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr <= 1'b0;
        end else if (w_g0) begin
            r_rr <= 1'b1;
        end else if (w_g1) begin
            r_rr <= 1'b0;
        end
    end

    // Core issue register; operands are held when nothing legal is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_core_en   <= 1'b0;
            r_core_mode <= 2'd0;
            r_core_x    <= '0;
            r_core_y    <= '0;
            r_core_z    <= '0;
        end else begin
            r_core_en   <= w_issue;
            r_core_mode <= w_issue ? w_mode : 2'd0;
            if (w_issue) begin
                r_core_x <= w_x;
                r_core_y <= w_y;
                r_core_z <= w_z;
            end
        end
    end

    // Ownership tags ride alongside the core; bit 0 is the newest job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_v  <= '0;
            r_tag_id <= '0;
        end else begin
            r_tag_v  <= {r_tag_v[CORE_LAT-1:0], w_issue};
            r_tag_id <= {r_tag_id[CORE_LAT-1:0], w_g1};
        end
    end

    // Response strobes line up with the cycle the core result is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp0 <= 1'b0;
            r_rsp1 <= 1'b0;
        end else begin
            r_rsp0 <= r_tag_v[CORE_LAT] && !r_tag_id[CORE_LAT];
            r_rsp1 <= r_tag_v[CORE_LAT] &&  r_tag_id[CORE_LAT];
        end
    end

    // Illegal-mode jobs are swallowed with a one-cycle error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
        end else begin
            r_err0 <= w_g0 && !w_legal;
            r_err1 <= w_g1 && !w_legal;
        end
    end

    // Outstanding job count; a job leaves as its response is launched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            case ({w_issue, w_retire})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign req0_ready = w_g0;
    assign req1_ready = w_g1;
    assign rsp0_valid = r_rsp0;
    assign rsp1_valid = r_rsp1;
    assign rsp_r      = core_r;
    assign rsp_a      = core_a;
    assign err0       = r_err0;
    assign err1       = r_err1;
    assign core_en    = r_core_en;
    assign core_mode  = r_core_mode;
    assign core_x     = r_core_x;
    assign core_y     = r_core_y;
    assign core_z     = r_core_z;
    assign in_flight  = r_inflight;
    assign idle       = (r_inflight == '0) && !r_core_en;

endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched: directed bench with a stand-in fixed-latency core,
// a scoreboard queue of expected responses and a decoupled response monitor.
module tb_cordic_sched;

    localparam int IW  = 17;
    localparam int OW  = 17;
    localparam int LAT = 18;
    localparam int CW  = 5;

    logic          clk;
    logic          rst_n;
    logic          hold;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [1:0]    req0_mode, req1_mode;
    logic [IW-1:0] req0_x, req0_y, req0_z;
    logic [IW-1:0] req1_x, req1_y, req1_z;
    logic          rsp0_valid, rsp1_valid;
    logic [OW-1:0] rsp_r, rsp_a;
    logic          err0, err1;
    logic          core_en;
    logic [1:0]    core_mode;
    logic [IW-1:0] core_x, core_y, core_z;
    logic [OW-1:0] core_r, core_a;
    logic [CW-1:0] in_flight;
    logic          idle;

    cordic_sched #(
        .IN_WIDTH(IW), .OUT_WIDTH(OW), .CORE_LAT(LAT), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_mode(req0_mode), .req0_x(req0_x),
        .req0_y(req0_y), .req0_z(req0_z),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_mode(req1_mode), .req1_x(req1_x),
        .req1_y(req1_y), .req1_z(req1_z),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_r(rsp_r), .rsp_a(rsp_a),
        .err0(err0), .err1(err1),
        .core_en(core_en), .core_mode(core_mode),
        .core_x(core_x), .core_y(core_y), .core_z(core_z),
        .core_r(core_r), .core_a(core_a),
        .in_flight(in_flight), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [OW-1:0] fr(input logic [IW-1:0] x,
                                         input logic [IW-1:0] y);
        return OW'(x + y);
    endfunction

    function automatic logic [OW-1:0] fa(input logic [IW-1:0] z,
                                         input logic [IW-1:0] x,
                                         input logic [1:0] m);
        return OW'(z ^ x ^ {15'd0, m});
    endfunction

    // Stand-in core: samples on en, result held LAT edges after sampling.
    logic [OW-1:0] cp_r [0:LAT];
    logic [OW-1:0] cp_a [0:LAT];
    always @(posedge clk) begin
        for (int i = LAT; i > 0; i--) begin
            cp_r[i] <= cp_r[i-1];
            cp_a[i] <= cp_a[i-1];
        end
        cp_r[0] <= core_en ? fr(core_x, core_y) : '0;
        cp_a[0] <= core_en ? fa(core_z, core_x, core_mode) : '0;
    end
    assign core_r = cp_r[LAT];
    assign core_a = cp_a[LAT];

    typedef struct {
        logic          id;
        logic [OW-1:0] r;
        logic [OW-1:0] a;
        int            c;
    } exp_t;

    exp_t sb[$];
    int   mf[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic          m_rr;
    logic          e_en, e_err0, e_err1;
    logic [1:0]    e_mode;
    logic [IW-1:0] e_x, e_y, e_z;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard whenever a response strobe appears.
    exp_t me;
    always @(negedge clk) begin
        if (rst_n && (rsp0_valid || rsp1_valid)) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_spurious @cyc %0d: got %b%b want none",
                         cyc, rsp1_valid, rsp0_valid);
            end else begin
                me = sb.pop_front();
                chk("rsp_vld", {30'd0, rsp1_valid, rsp0_valid},
                    me.id ? 32'd2 : 32'd1);
                chk("rsp_cyc", cyc, me.c);
                chk("rsp_r", rsp_r, me.r);
                chk("rsp_a", rsp_a, me.a);
            end
        end
    end

    task automatic step(input logic h,
                        input logic v0, input logic [1:0] m0,
                        input logic [IW-1:0] x0, input logic [IW-1:0] y0,
                        input logic [IW-1:0] z0,
                        input logic v1, input logic [1:0] m1,
                        input logic [IW-1:0] x1, input logic [IW-1:0] y1,
                        input logic [IW-1:0] z1);
        logic g0, g1, l0, l1, lg;
        exp_t e;
        hold = h;
        req0_valid = v0; req0_mode = m0;
        req0_x = x0; req0_y = y0; req0_z = z0;
        req1_valid = v1; req1_mode = m1;
        req1_x = x1; req1_y = y1; req1_z = z1;
        #1;
        g0 = !h && v0 && (!v1 || !m_rr);
        g1 = !h && v1 && (!v0 || m_rr);
        l0 = (m0 == 2'd1) || (m0 == 2'd2);
        l1 = (m1 == 2'd1) || (m1 == 2'd2);
        chk("ready0", {31'd0, req0_ready}, {31'd0, g0});
        chk("ready1", {31'd0, req1_ready}, {31'd0, g1});
        lg = (g0 && l0) || (g1 && l1);
        if (lg) begin
            e.id = g1;
            e.r  = g1 ? fr(x1, y1) : fr(x0, y0);
            e.a  = g1 ? fa(z1, x1, m1) : fa(z0, x0, m0);
            e.c  = cyc + 1 + LAT + 1;
            sb.push_back(e);
            mf.push_back(e.c);
        end
        @(posedge clk);
        e_err0 = g0 && !l0;
        e_err1 = g1 && !l1;
        e_en   = lg;
        e_mode = lg ? (g1 ? m1 : m0) : 2'd0;
        if (lg) begin
            e_x = g1 ? x1 : x0;
            e_y = g1 ? y1 : y0;
            e_z = g1 ? z1 : z0;
        end
        if (g0) m_rr = 1'b1;
        else if (g1) m_rr = 1'b0;
        @(negedge clk);
        while (mf.size() > 0 && mf[0] <= cyc) void'(mf.pop_front());
        chk("core_en", {31'd0, core_en}, {31'd0, e_en});
        chk("core_mode", {30'd0, core_mode}, {30'd0, e_mode});
        chk("core_x", {15'd0, core_x}, {15'd0, e_x});
        chk("core_y", {15'd0, core_y}, {15'd0, e_y});
        chk("core_z", {15'd0, core_z}, {15'd0, e_z});
        chk("err0", {31'd0, err0}, {31'd0, e_err0});
        chk("err1", {31'd0, err1}, {31'd0, e_err1});
        chk("in_flight", {27'd0, in_flight}, mf.size());
        chk("idle", {31'd0, idle}, {31'd0, (mf.size() == 0) && !e_en});
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 2'd0, '0, '0, '0, 1'b0, 2'd0, '0, '0, '0);
    endtask

    task automatic do_reset();
        hold = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        mf.delete();
        m_rr = 1'b0;
        e_en = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0; e_mode = 2'd0;
        e_x = '0; e_y = '0; e_z = '0;
        #1;
        chk("rst_core_en", {31'd0, core_en}, 32'd0);
        chk("rst_core_x", {15'd0, core_x}, 32'd0);
        chk("rst_in_flight", {27'd0, in_flight}, 32'd0);
        chk("rst_idle", {31'd0, idle}, 32'd1);
        chk("rst_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("rst_err", {30'd0, err1, err0}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        hold = 1'b0;
        req0_valid = 1'b0; req0_mode = 2'd0;
        req0_x = '0; req0_y = '0; req0_z = '0;
        req1_valid = 1'b0; req1_mode = 2'd0;
        req1_x = '0; req1_y = '0; req1_z = '0;
        @(negedge clk);
        do_reset();

        // single requester, full latency
        step(1'b0, 1'b1, 2'd1, 17'd30000, 17'd40000, 17'd0,
             1'b0, 2'd0, '0, '0, '0);
        nop(22);

        // contention from reset: alternating grants
        do_reset();
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 2'd1, IW'(1000 + i), IW'(2000 + 3 * i), 17'd0,
                 1'b1, 2'd2, 17'd50000, 17'd0, 17'd0);
        nop(22);

        // back-to-back single requester 1
        for (int i = 0; i < 7; i++)
            step(1'b0, 1'b0, 2'd0, '0, '0, '0,
                 1'b1, 2'd1, 17'd65535, 17'h10000, IW'(i));
        nop(22);

        // illegal modes on both ports
        step(1'b0, 1'b1, 2'd3, 17'd5, 17'd6, 17'd7,
             1'b0, 2'd0, '0, '0, '0);
        step(1'b0, 1'b0, 2'd0, '0, '0, '0,
             1'b1, 2'd0, 17'd8, 17'd9, 17'd10);
        nop(3);

        // hold with outstanding jobs, then release
        step(1'b0, 1'b1, 2'd2, 17'd111, 17'd222, 17'd333,
             1'b1, 2'd1, 17'd444, 17'd555, 17'd666);
        step(1'b0, 1'b1, 2'd2, 17'd112, 17'd223, 17'd334,
             1'b1, 2'd1, 17'd445, 17'd556, 17'd667);
        step(1'b0, 1'b1, 2'd2, 17'd113, 17'd224, 17'd335,
             1'b0, 2'd0, '0, '0, '0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 2'd2, 17'd114, 17'd225, 17'd336,
                 1'b1, 2'd1, 17'd446, 17'd557, 17'd668);
        step(1'b0, 1'b1, 2'd2, 17'd114, 17'd225, 17'd336,
             1'b1, 2'd1, 17'd446, 17'd557, 17'd668);
        nop(22);

        // reset with three jobs in flight: no responses afterwards
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 2'd1, IW'(7 * i + 1), IW'(9 * i + 2), 17'd0,
                 1'b0, 2'd0, '0, '0, '0);
        nop(4);
        do_reset();
        nop(25);

        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
